// File: rtl/mem_access_pkg.sv
// Shared bus widths, access-size encodings and the MEM/WB bundle record.
package mem_access_pkg;

  localparam int DATA_BUS     = 32;
  localparam int ADDR_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
  localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic                    write_reg_en;
    logic [REG_ADDR_BUS-1:0] write_reg_addr;
    logic                    hilo_write_en;
    logic [DATA_BUS-1:0]     hi;
    logic [DATA_BUS-1:0]     lo;
    logic [ADDR_BUS-1:0]     debug_pc;
    logic                    rd;
    logic                    wr;
    logic                    sext;
    logic [3:0]              sel;
    logic [DATA_BUS-1:0]     result;
  } wb_bundle_t;

endpackage

// File: rtl/mem_lane_align.sv
// Access-size decode, store-lane replication and misalignment detection.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]          sel,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [1:0]          size,
  output logic [DATA_BUS-1:0] wdata_rep,
  output logic                misaligned
);

  // Anything that is not a half or word select is treated as a byte access.
  always_comb begin
    size       = DATA_SIZE_BYTE;
    wdata_rep  = {4{wdata[7:0]}};
    misaligned = 1'b0;
    case (sel)
      MEM_SEL_WORD: begin
        size       = DATA_SIZE_WORD;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      MEM_SEL_HALF: begin
        size       = DATA_SIZE_HALF;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: drives an SRAM-like data bus and registers the MEM/WB bundle.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    mem_read_flag_in,
  input  logic                    mem_write_flag_in,
  input  logic                    mem_sign_ext_flag_in,
  input  logic [3:0]              mem_sel_in,
  input  logic [DATA_BUS-1:0]     mem_write_data_in,
  input  logic [DATA_BUS-1:0]     result_in,
  input  logic                    write_reg_en_in,
  input  logic [REG_ADDR_BUS-1:0] write_reg_addr_in,
  input  logic                    hilo_write_en_in,
  input  logic [DATA_BUS-1:0]     hi_in,
  input  logic [DATA_BUS-1:0]     lo_in,
  input  logic [ADDR_BUS-1:0]     debug_pc_addr_in,
  input  logic                    flush,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [ADDR_BUS-1:0]     data_addr,
  output logic [DATA_BUS-1:0]     data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [DATA_BUS-1:0]     data_rdata,
  output logic                    stall_request,
  output logic                    adel,
  output logic                    ades,
  output logic                    mem_read_flag,
  output logic                    mem_write_flag,
  output logic                    mem_sign_ext_flag,
  output logic [3:0]              mem_sel,
  output logic [DATA_BUS-1:0]     ram_read_data,
  output logic [DATA_BUS-1:0]     result_out,
  output logic                    write_reg_en,
  output logic [REG_ADDR_BUS-1:0] write_reg_addr,
  output logic                    hilo_write_en,
  output logic [DATA_BUS-1:0]     hi,
  output logic [DATA_BUS-1:0]     lo,
  output logic [ADDR_BUS-1:0]     debug_pc_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state, state_next;
  wb_bundle_t          in_bundle, pend, bundle;
  logic [1:0]          size_c;
  logic [DATA_BUS-1:0] wdata_c;
  logic                misaligned;
  logic                is_mem, start, capture;
  logic                req_wr;
  logic [1:0]          req_size;
  logic [ADDR_BUS-1:0] req_addr;
  logic [DATA_BUS-1:0] req_wdata, rdata_cap;

  mem_lane_align u_align (
    .sel       (mem_sel_in),
    .addr_lo   (result_in[1:0]),
    .wdata     (mem_write_data_in),
    .size      (size_c),
    .wdata_rep (wdata_c),
    .misaligned(misaligned)
  );

  // Collect the incoming slot into one record.
  always_comb begin
    in_bundle                = '0;
    in_bundle.write_reg_en   = write_reg_en_in;
    in_bundle.write_reg_addr = write_reg_addr_in;
    in_bundle.hilo_write_en  = hilo_write_en_in;
    in_bundle.hi             = hi_in;
    in_bundle.lo             = lo_in;
    in_bundle.debug_pc       = debug_pc_addr_in;
    in_bundle.rd             = mem_read_flag_in;
    in_bundle.wr             = mem_write_flag_in;
    in_bundle.sext           = mem_sign_ext_flag_in;
    in_bundle.sel            = mem_sel_in;
    in_bundle.result         = result_in;
  end

  assign is_mem = valid_in & (mem_read_flag_in | mem_write_flag_in);
  assign start  = is_mem & ~flush & ~misaligned;

  // Next state, stall and capture strobe; data_ok outside REQ/WAIT is ignored.
  always_comb begin
    state_next    = state;
    stall_request = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next    = REQ;
        stall_request = 1'b1;
      end
      REQ: begin
        stall_request = 1'b1;
        if (data_addr_ok) begin
          state_next = data_data_ok ? DONE : WAIT;
          capture    = data_data_ok;
        end
      end
      WAIT: begin
        stall_request = 1'b1;
        if (data_data_ok) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign data_req   = (state == REQ);
  assign data_wr    = data_req & req_wr;
  assign data_size  = req_size;
  assign data_addr  = req_addr;
  assign data_wdata = req_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Latch the bus request and the slot at launch; capture read data raw.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_wr    <= 1'b0;
      req_size  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      pend      <= '0;
      rdata_cap <= '0;
    end else begin
      if (state == IDLE && start) begin
        req_wr    <= mem_write_flag_in;
        req_size  <= size_c;
        req_addr  <= result_in;
        req_wdata <= wdata_c;
        pend      <= in_bundle;
      end
      if (capture) rdata_cap <= data_rdata;
    end
  end

  // MEM/WB bundle: bubble unless a slot completes this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bundle        <= '0;
      ram_read_data <= '0;
      adel          <= 1'b0;
      ades          <= 1'b0;
    end else begin
      bundle        <= '0;
      ram_read_data <= '0;
      adel          <= 1'b0;
      ades          <= 1'b0;
      case (state)
        IDLE: if (valid_in && !flush && !start) begin
          bundle <= in_bundle;
          if (is_mem) begin
            // Misaligned access: kill the writeback and raise the exception.
            bundle.write_reg_en <= 1'b0;
            bundle.rd           <= 1'b0;
            bundle.wr           <= 1'b0;
            bundle.sext         <= 1'b0;
            adel                <= mem_read_flag_in;
            ades                <= mem_write_flag_in & ~mem_read_flag_in;
          end
        end
        DONE: if (!flush) begin
          bundle        <= pend;
          ram_read_data <= pend.wr ? '0 : rdata_cap;
        end
        default: ;
      endcase
    end
  end

  assign write_reg_en      = bundle.write_reg_en;
  assign write_reg_addr    = bundle.write_reg_addr;
  assign hilo_write_en     = bundle.hilo_write_en;
  assign hi                = bundle.hi;
  assign lo                = bundle.lo;
  assign debug_pc_addr     = bundle.debug_pc;
  assign mem_read_flag     = bundle.rd;
  assign mem_write_flag    = bundle.wr;
  assign mem_sign_ext_flag = bundle.sext;
  assign mem_sel           = bundle.sel;
  assign result_out        = bundle.result;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed table, corner sequences, random ops.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        hilo_write_en_in;
  logic [31:0] hi_in, lo_in, debug_pc_addr_in;
  logic        flush;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_request, adel, ades;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] ram_read_data, result_out;
  logic        write_reg_en;
  logic [4:0]  write_reg_addr;
  logic        hilo_write_en;
  logic [31:0] hi, lo, debug_pc_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
    .mem_write_data_in(mem_write_data_in), .result_in(result_in),
    .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
    .hilo_write_en_in(hilo_write_en_in), .hi_in(hi_in), .lo_in(lo_in),
    .debug_pc_addr_in(debug_pc_addr_in), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall_request(stall_request), .adel(adel), .ades(ades),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
    .ram_read_data(ram_read_data), .result_out(result_out),
    .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr),
    .hilo_write_en(hilo_write_en), .hi(hi), .lo(lo), .debug_pc_addr(debug_pc_addr)
  );

  typedef struct packed {
    logic valid, flush, rd, wr, sx;
    logic [3:0]  sel;
    logic [31:0] wd, addr;
    logic        we;
    logic [4:0]  wa;
    logic        hle;
    logic [31:0] hi, lo, pc;
  } instr_t;

  typedef struct packed {
    logic adel, ades, rd, wr, sx;
    logic [3:0]  sel;
    logic [31:0] rrd, res;
    logic        we;
    logic [4:0]  wa;
    logic        hle;
    logic [31:0] hi, lo, pc;
  } out_t;

  typedef struct {
    instr_t      in;
    int          stalls;
    logic        adel, ades, we;
    logic [31:0] res;
  } vec_t;

  function automatic instr_t mk(logic v, logic f, logic r, logic w, logic [3:0] s,
                                logic [31:0] a, logic [31:0] d, logic we, logic [4:0] wa,
                                logic [31:0] pc);
    instr_t x;
    x.valid = v; x.flush = f; x.rd = r; x.wr = w; x.sx = r & a[4];
    x.sel = s; x.wd = d; x.addr = a; x.we = we; x.wa = wa; x.hle = a[2];
    x.hi = ~a; x.lo = a ^ pc; x.pc = pc;
    return x;
  endfunction

  // Reference rules, stated directly from the block's behaviour description.
  function automatic logic misal(instr_t x);
    return (x.sel == 4'b0011 && x.addr % 2 != 0) || (x.sel == 4'b1111 && x.addr % 4 != 0);
  endfunction

  function automatic logic goes_to_bus(instr_t x);
    return x.valid && !x.flush && (x.rd || x.wr) && !misal(x);
  endfunction

  function automatic out_t model(instr_t x, logic [31:0] word);
    out_t o = '0;
    if (!x.valid || x.flush) return o;
    o.sel = x.sel; o.res = x.addr; o.we = x.we; o.wa = x.wa; o.hle = x.hle;
    o.hi = x.hi; o.lo = x.lo; o.pc = x.pc; o.rd = x.rd; o.wr = x.wr; o.sx = x.sx;
    if ((x.rd || x.wr) && misal(x)) begin
      o.we = 1'b0; o.rd = 1'b0; o.wr = 1'b0; o.sx = 1'b0;
      o.adel = x.rd; o.ades = x.wr;
    end else if (x.rd) begin
      o.rrd = word;
    end
    return o;
  endfunction

  function automatic logic [31:0] rep(logic [3:0] s, logic [31:0] d);
    if (s == 4'b1111) return d;
    if (s == 4'b0011) return d[15:0] * 32'h0001_0001;
    return d[7:0] * 32'h0101_0101;
  endfunction

  function automatic logic [1:0] sz(logic [3:0] s);
    if (s == 4'b1111) return 2'd2;
    if (s == 4'b0011) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.adel = adel; o.ades = ades; o.rd = mem_read_flag; o.wr = mem_write_flag;
    o.sx = mem_sign_ext_flag; o.sel = mem_sel; o.rrd = ram_read_data; o.res = result_out;
    o.we = write_reg_en; o.wa = write_reg_addr; o.hle = hilo_write_en;
    o.hi = hi; o.lo = lo; o.pc = debug_pc_addr;
    return o;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t x);
    valid_in = x.valid; flush = x.flush; mem_read_flag_in = x.rd; mem_write_flag_in = x.wr;
    mem_sign_ext_flag_in = x.sx; mem_sel_in = x.sel; mem_write_data_in = x.wd;
    result_in = x.addr; write_reg_en_in = x.we; write_reg_addr_in = x.wa;
    hilo_write_en_in = x.hle; hi_in = x.hi; lo_in = x.lo; debug_pc_addr_in = x.pc;
  endtask

  // Present x until the stage releases it, acting as the bus slave with the
  // given address/data delays. Returns at edge+1 after the slot completes.
  task automatic run_one(input instr_t x, input int aw, input int dw, input logic [31:0] rdata,
                         output int stalls, output int reqs);
    logic [66:0] bus0;
    logic seen, acc, done;
    int awc, dwc, cyc;
    seen = 1'b0; acc = 1'b0; done = 1'b0; awc = aw; dwc = dw; cyc = 0;
    bus0 = '0; stalls = 0; reqs = 0;
    drive(x);
    while (!done && cyc < 64) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      if (data_req) begin
        reqs++;
        if (!seen) begin
          seen = 1'b1;
          bus0 = {data_wr, data_size, data_addr, data_wdata};
          chk("bus_req", 96'(bus0), 96'({x.wr, sz(x.sel), x.addr, rep(x.sel, x.wd)}));
        end else begin
          chk("bus_hold", 96'({data_wr, data_size, data_addr, data_wdata}), 96'(bus0));
        end
        if (awc == 0) begin
          data_addr_ok = 1'b1; acc = 1'b1;
          if (dwc == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
        end else awc--;
      end else if (acc && dwc > 0) begin
        dwc--;
        if (dwc == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
      end else if ($urandom_range(3) == 0) begin
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_0000 | 32'($urandom_range(16'hFFFF));
      end
      #1;
      if (stall_request) stalls++; else done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("slot_timeout", 96'(done), 96'(1));
  endtask

  task automatic do_instr(input string name, input instr_t x, input int aw, input int dw,
                          input logic [31:0] rdata);
    int st, rq;
    run_one(x, aw, dw, rdata, st, rq);
    chk_out(name, observe(), model(x, rdata));
    chk({name, "_stall"}, 96'(st), 96'(goes_to_bus(x) ? aw + dw + 2 : 0));
    chk({name, "_req"}, 96'(rq), 96'(goes_to_bus(x) ? aw + 1 : 0));
  endtask

  initial begin
    vec_t   vt[11];
    instr_t x;
    int     st, rq;
    logic [3:0]  s;
    logic [31:0] a;
    logic        r;
    int          kind;

    rst = 1'b0;
    drive('0);
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_bundle", observe(), '0);
    chk("reset_ctl", 96'({data_req, stall_request, adel, ades}), 96'(0));

    // Directed single-slot vectors; the first one sees the first edge with rst=1.
    vt[0]  = '{mk(1,0,0,0,4'hF,32'h0000_0007,0,1,3,32'hBFC0_0000), 0, 0, 0, 1, 32'h0000_0007};
    vt[1]  = '{mk(1,0,1,0,4'h3,32'h0000_1001,0,1,4,32'hBFC0_0004), 0, 1, 0, 0, 32'h0000_1001};
    vt[2]  = '{mk(1,0,0,1,4'hF,32'h0000_2002,5,0,0,32'hBFC0_0008), 0, 0, 1, 0, 32'h0000_2002};
    vt[3]  = '{mk(1,0,1,0,4'hF,32'h0000_3006,0,1,5,32'hBFC0_000C), 0, 1, 0, 0, 32'h0000_3006};
    vt[4]  = '{mk(1,0,0,1,4'h3,32'h0000_4003,9,0,0,32'hBFC0_0010), 0, 0, 1, 0, 32'h0000_4003};
    vt[5]  = '{mk(1,1,0,0,4'hF,32'h0000_0011,0,1,6,32'hBFC0_0014), 0, 0, 0, 0, 32'h0};
    vt[6]  = '{mk(0,0,1,0,4'h1,32'h0000_0022,0,1,7,32'hBFC0_0018), 0, 0, 0, 0, 32'h0};
    vt[7]  = '{mk(1,0,0,0,4'hF,32'h0000_0005,0,1,8,32'hBFC0_001C), 0, 0, 0, 1, 32'h0000_0005};
    vt[8]  = '{mk(1,0,1,0,4'h1,32'h0000_4003,0,1,9,32'hBFC0_0020), 2, 0, 0, 1, 32'h0000_4003};
    vt[9]  = '{mk(1,0,1,0,4'h3,32'h0000_6002,0,1,10,32'hBFC0_0024), 2, 0, 0, 1, 32'h0000_6002};
    vt[10] = '{mk(1,0,0,1,4'hF,32'h0000_0008,7,0,0,32'hBFC0_0028), 2, 0, 0, 0, 32'h0000_0008};
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_one(vt[i].in, 0, 0, 32'h0, st, rq);
      chk($sformatf("vec%0d", i), 96'({st[3:0], adel, ades, write_reg_en, result_out}),
          96'({vt[i].stalls[3:0], vt[i].adel, vt[i].ades, vt[i].we, vt[i].res}));
    end

    // Word load, accepted and answered in the first REQ cycle.
    x = mk(1,0,1,0,4'hF,32'h8000_1000,0,1,2,32'hBFC0_0100);
    do_instr("wload_fast", x, 0, 0, 32'hDEAD_BEEF);
    chk("wload_fast_data", 96'({ram_read_data, mem_sel}), 96'({32'hDEAD_BEEF, 4'hF}));

    // Byte store with addr_ok held off three cycles.
    x = mk(1,0,0,1,4'h1,32'h1000_0003,32'h0000_00A5,0,0,32'hBFC0_0104);
    do_instr("bstore_slow", x, 3, 1, 32'h0);

    // Word load with data_ok five cycles after addr_ok.
    x = mk(1,0,1,0,4'hF,32'h0000_0040,0,1,6,32'hBFC0_0108);
    do_instr("wload_wait", x, 0, 5, 32'h1234_5678);

    // ALU op, then a load, then a flushed slot.
    do_instr("alu_r3", mk(1,0,0,0,4'h0,32'h7,0,1,3,32'hBFC0_010C), 0, 0, 32'h0);
    do_instr("seq_load", mk(1,0,1,0,4'h3,32'h0000_0102,0,1,4,32'hBFC0_0110), 1, 2, 32'h0BAD_F00D);
    do_instr("seq_flush", mk(1,1,0,0,4'h0,32'h9,0,1,5,32'hBFC0_0114), 0, 0, 32'h0);

    // Reset while waiting for data, then a stray data_ok.
    x = mk(1,0,1,0,4'hF,32'h0000_2000,0,1,7,32'hBFC0_0118);
    drive(x);
    @(posedge clk); #1;
    chk("rst_req", 96'(data_req), 96'(1));
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    chk("rst_wait_stall", 96'({data_req, stall_request}), 96'(2'b01));
    rst = 1'b0;
    drive('0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_out("rst_bundle", observe(), '0);
    chk("rst_ctl", 96'({data_req, stall_request, adel, ades}), 96'(0));
    data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    chk_out("stray_bundle", observe(), '0);
    chk("stray_ctl", 96'({data_req, stall_request}), 96'(0));
    do_instr("after_rst", mk(1,0,1,0,4'hF,32'h0000_3000,0,1,8,32'hBFC0_011C), 1, 1, 32'hCAFE_0001);

    // Randomized slots against the reference rules.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(9);
      case ($urandom_range(2))
        0:       s = 4'h1;
        1:       s = 4'h3;
        default: s = 4'hF;
      endcase
      a = $urandom;
      r = 1'($urandom_range(1));
      if (kind <= 3) begin
        x = mk(1,0,0,0,s,a,$urandom,1'($urandom_range(1)),5'($urandom),$urandom | 32'h1);
      end else if (kind <= 7) begin
        if (s == 4'hF) a[1:0] = 2'b00;
        if (s == 4'h3) a[0] = 1'b0;
        x = mk(1,0,r,!r,s,a,$urandom,r,5'($urandom),$urandom | 32'h1);
      end else if (kind == 8) begin
        if ($urandom_range(1) == 0) begin s = 4'h3; a[0] = 1'b1; end
        else begin s = 4'hF; if (a[1:0] == 2'b00) a[1:0] = 2'($urandom_range(3, 1)); end
        x = mk(1,0,r,!r,s,a,$urandom,1,5'($urandom),$urandom | 32'h1);
      end else begin
        x = mk(1'($urandom_range(1)),1'($urandom_range(1)),r,!r,s,a,$urandom,1,5'($urandom),
               $urandom | 32'h1);
        if (x.valid) x.flush = 1'b1;
      end
      do_instr($sformatf("rnd%0d", n), x, $urandom_range(3), $urandom_range(4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
